button_encoder: RTL

BUTTON_ENCODER -- requirements
Module: button_encoder

---
 rtl/button_encoder.sv | 78 +++++++
 1 files changed

// File: rtl/button_encoder.sv
// button_encoder: synchronized, debounced 4-button priority encoder with one-shot capture.
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [1:0] code,
    output logic       valid,
    output logic       held,
    output logic       multi
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic {IDLE, PRESSED} state_t;
    state_t r_state;
    logic [3:0] r_s1, r_s2;
    logic [3:0] w_db;
    logic [1:0] w_code;
    logic       w_multi;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CW-1:0] r_cnt;
        logic          r_st;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_st  <= 1'b0;
            end else if (r_s2[i] == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_st  <= r_s2[i];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
        assign w_db[i] = r_st;
    end
    always_comb begin
        w_code  = w_db[3] ? 2'd3 : w_db[2] ? 2'd2 : w_db[1] ? 2'd1 : 2'd0;
        // more than one bit set iff clearing the lowest set bit leaves something
        w_multi = (w_db & (w_db - 4'd1)) != 4'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            code    <= 2'd0;
            valid   <= 1'b0;
            held    <= 1'b0;
            multi   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                IDLE: if (w_db != 4'd0) begin
                    r_state <= PRESSED;
                    code    <= w_code;
                    multi   <= w_multi;
                    valid   <= 1'b1;
                    held    <= 1'b1;
                end
                PRESSED: if (w_db == 4'd0) begin
                    r_state <= IDLE;
                    held    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
